// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution scheduler.
// Holds the FSM state encoding and the address/counter widths.
package conv_pkg;

    localparam int IA_W  = 12;
    localparam int WA_W  = 10;
    localparam int RA_W  = 4;
    localparam int DIM_W = 5;
    localparam int CH_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EXEC,
        S_FIN,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Kernel walk counters (kx fastest, then ky, then channel) and the
// incremental src/weight address generator; adders only.
module conv_addr_gen
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic             wadv,
    input  logic [CH_W-1:0]  id,
    input  logic [DIM_W-1:0] iw,
    input  logic [DIM_W-1:0] kh,
    input  logic [DIM_W-1:0] kw,
    input  logic [WA_W-1:0]  src_sz,
    input  logic [IA_W-1:0]  pbase,
    output logic [IA_W-1:0]  ia,
    output logic [WA_W-1:0]  wa
);

    logic [DIM_W-1:0] kx;
    logic [DIM_W-1:0] ky;
    logic [CH_W-1:0]  c;
    logic [IA_W-1:0]  rbase;
    logic [IA_W-1:0]  cbase;
    logic             last_el;

    assign last_el = (c == id) && (ky == kh - 5'd1) && (kx == kw - 5'd1);

    // The walk parks on the final element so ia holds it after EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx    <= '0;
            ky    <= '0;
            c     <= '0;
            rbase <= '0;
            cbase <= '0;
            wa    <= '0;
        end else if (clr) begin
            kx    <= '0;
            ky    <= '0;
            c     <= '0;
            rbase <= '0;
            cbase <= '0;
            wa    <= '0;
        end else begin
            if (adv && !last_el) begin
                if (kx != kw - 5'd1) begin
                    kx <= kx + 5'd1;
                end else begin
                    kx <= '0;
                    if (ky != kh - 5'd1) begin
                        ky    <= ky + 5'd1;
                        rbase <= rbase + {{(IA_W-DIM_W){1'b0}}, iw};
                    end else begin
                        ky    <= '0;
                        rbase <= '0;
                        c     <= c + 4'd1;
                        cbase <= cbase + {{(IA_W-WA_W){1'b0}}, src_sz};
                    end
                end
            end
            if (wadv) wa <= wa + 10'd1;
        end
    end

    assign ia = pbase + cbase + rbase + {{(IA_W-DIM_W){1'b0}}, kx};

endmodule

// File: rtl/conv_sched.sv
// Convolution sample scheduler: INIT/EXEC/FIN/OUT per output position.
// Optional CONV_SCHED_STALL_EN adds a stall input that freezes the sequence.
module conv_sched
    import conv_pkg::*;
#(
    parameter int F_NUM = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             s_init,
    output logic             s_fin,
    output logic             k_init,
    output logic             k_fin,
    output logic             exec,
    output logic [IA_W-1:0]  ia,
    output logic [WA_W-1:0]  wa,
    output logic [RA_W-1:0]  ra,
    output logic             outr,
    output logic [IA_W-1:0]  oa,
`ifdef CONV_SCHED_STALL_EN
    input  logic             stall,
`endif
    input  logic [CH_W-1:0]  id,
    input  logic [CH_W-1:0]  od,
    input  logic [DIM_W-1:0] ih,
    input  logic [DIM_W-1:0] iw,
    input  logic [DIM_W-1:0] oh,
    input  logic [DIM_W-1:0] ow,
    input  logic [DIM_W-1:0] kh,
    input  logic [DIM_W-1:0] kw,
    input  logic [WA_W-1:0]  is,
    input  logic [WA_W-1:0]  os,
    input  logic [WA_W-1:0]  fs
);

    state_t           state;
    state_t           state_nx;
    logic             hold;
    logic             step;
    logic             last_wa;
    logic             last_ra;
    logic             last_pos;
    logic [DIM_W-1:0] ox;
    logic [DIM_W-1:0] oy;
    logic [IA_W-1:0]  prow;
    logic [IA_W-1:0]  orow;
    logic [IA_W-1:0]  obase;
    logic             outr_q;
    logic             unused_cfg;

`ifdef CONV_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign unused_cfg = ^{ih, (F_NUM > 0)};

    assign step     = run && !hold;
    assign last_wa  = (wa == fs - 10'd1);
    assign last_ra  = (ra == od);
    assign last_pos = (ox == ow - 5'd1) && (oy == oh - 5'd1);

    always_comb begin
        state_nx = state;
        if (!run) begin
            state_nx = S_IDLE;
        end else if (!hold) begin
            unique case (state)
                S_IDLE:  if (s_init) state_nx = S_INIT;
                S_INIT:  state_nx = S_EXEC;
                S_EXEC:  if (last_wa) state_nx = S_FIN;
                S_FIN:   state_nx = S_OUT;
                S_OUT:   if (last_ra) state_nx = last_pos ? S_DONE : S_INIT;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    conv_addr_gen u_addr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (step && state != S_INIT && state_nx == S_INIT),
        .adv    (step && (state == S_INIT || state == S_EXEC)),
        .wadv   (step && state == S_EXEC && !last_wa),
        .id     (id),
        .iw     (iw),
        .kh     (kh),
        .kw     (kw),
        .src_sz (is),
        .pbase  (prow + {{(IA_W-DIM_W){1'b0}}, ox}),
        .ia     (ia),
        .wa     (wa)
    );

    // Position walk: prow tracks oy*iw and orow tracks oy*ow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox   <= '0;
            oy   <= '0;
            prow <= '0;
            orow <= '0;
        end else if (step && state == S_IDLE && s_init) begin
            ox   <= '0;
            oy   <= '0;
            prow <= '0;
            orow <= '0;
        end else if (step && state == S_OUT && last_ra && !last_pos) begin
            if (ox != ow - 5'd1) begin
                ox <= ox + 5'd1;
            end else begin
                ox   <= '0;
                oy   <= oy + 5'd1;
                prow <= prow + {{(IA_W-DIM_W){1'b0}}, iw};
                orow <= orow + {{(IA_W-DIM_W){1'b0}}, ow};
            end
        end
    end

    // Sum readout: oa/outr are registered alongside the core select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            obase  <= '0;
            oa     <= '0;
            outr_q <= 1'b0;
        end else begin
            if (!run)      outr_q <= 1'b0;
            else if (!hold) outr_q <= (state == S_OUT);
            if (step && state == S_FIN) begin
                ra    <= '0;
                obase <= '0;
            end else if (step && state == S_OUT) begin
                oa    <= obase + orow + {{(IA_W-DIM_W){1'b0}}, ox};
                obase <= obase + {{(IA_W-WA_W){1'b0}}, os};
                if (!last_ra) ra <= ra + 4'd1;
            end
        end
    end

    assign k_init = (state == S_INIT) && !hold;
    assign exec   = (state == S_EXEC) && !hold;
    assign k_fin  = (state == S_FIN)  && !hold;
    assign s_fin  = (state == S_DONE) && !hold;
    assign outr   = outr_q && !hold;

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched against a per-cycle trace model
// built from output positions, kernel elements and readout rows.
module tb_conv_sched;

    logic        clk = 1'b0;
    logic        rst_n, run, s_init;
    logic        s_fin, k_init, k_fin, exec, outr;
    logic [11:0] ia, oa;
    logic [9:0]  wa;
    logic [3:0]  ra;
    logic [3:0]  id, od;
    logic [4:0]  ih, iw, oh, ow, kh, kw;
    logic [9:0]  is_v, os_v, fs_v;

    typedef struct {
        logic ki, ex, kf, ot, sf;
        logic [11:0] ia;
        logic [9:0]  wa;
        logic [3:0]  ra;
        logic [11:0] oa;
        bit cia, cwa, cra, coa;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t obs_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    conv_sched #(.F_NUM(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .s_init(s_init),
        .s_fin(s_fin), .k_init(k_init), .k_fin(k_fin), .exec(exec),
        .ia(ia), .wa(wa), .ra(ra), .outr(outr), .oa(oa),
        .id(id), .od(od), .ih(ih), .iw(iw), .oh(oh), .ow(ow),
        .kh(kh), .kw(kw), .is(is_v), .os(os_v), .fs(fs_v)
    );

    function automatic cyc_t blank();
        cyc_t c;
        c = '{default: 0};
        return c;
    endfunction

    function automatic string fmt(cyc_t c);
        return $sformatf("ki%b ex%b kf%b ot%b sf%b ia%0d wa%0d ra%0d oa%0d",
            c.ki, c.ex, c.kf, c.ot, c.sf, c.ia, c.wa, c.ra, c.oa);
    endfunction

    function automatic bit ok(cyc_t e, cyc_t o);
        return ({e.ki, e.ex, e.kf, e.ot, e.sf} === {o.ki, o.ex, o.kf, o.ot, o.sf})
            && (!e.cia || o.ia === e.ia) && (!e.cwa || o.wa === e.wa)
            && (!e.cra || o.ra === e.ra) && (!e.coa || o.oa === e.oa);
    endfunction

    function automatic int src_addr(int y, int x, int n);
        int nkw, nkh, c, rem, ky, kx;
        nkw = kw;
        nkh = kh;
        c   = n / (nkw * nkh);
        rem = n % (nkw * nkh);
        ky  = rem / nkw;
        kx  = rem % nkw;
        return c * int'(is_v) + (y + ky) * int'(iw) + x + kx;
    endfunction

    // Whole-sample expected trace, one entry per clock starting at INIT.
    function automatic void gen_trace();
        cyc_t e;
        bit   pend;
        int   poa, nfs, nod;
        pend = 0;
        poa  = 0;
        nfs  = fs_v;
        nod  = od;
        exp_q.delete();
        for (int y = 0; y < int'(oh); y++) begin
            for (int x = 0; x < int'(ow); x++) begin
                e = blank(); e.ki = 1; e.cia = 1; e.ia = 12'(src_addr(y, x, 0));
                e.ot = pend; e.coa = pend; e.oa = 12'(poa);
                exp_q.push_back(e);
                pend = 0;
                for (int n = 0; n < nfs; n++) begin
                    e = blank(); e.ex = 1; e.cwa = 1; e.wa = 10'(n);
                    if (n + 1 < nfs) begin
                        e.cia = 1; e.ia = 12'(src_addr(y, x, n + 1));
                    end
                    exp_q.push_back(e);
                end
                e = blank(); e.kf = 1;
                exp_q.push_back(e);
                for (int r = 0; r <= nod; r++) begin
                    e = blank(); e.cra = 1; e.ra = 4'(r);
                    e.ot = pend; e.coa = pend; e.oa = 12'(poa);
                    exp_q.push_back(e);
                    pend = 1;
                    poa  = r * int'(os_v) + y * int'(ow) + x;
                end
            end
        end
        e = blank(); e.sf = 1; e.ot = pend; e.coa = pend; e.oa = 12'(poa);
        exp_q.push_back(e);
        e = blank();
        exp_q.push_back(e);
    endfunction

    task automatic set_cfg(input int i_d, o_d, o_h, o_w, k_h, k_w);
        int nih, niw;
        nih  = o_h + k_h - 1;
        niw  = o_w + k_w - 1;
        id   = 4'(i_d);  od = 4'(o_d);
        oh   = 5'(o_h);  ow = 5'(o_w);
        kh   = 5'(k_h);  kw = 5'(k_w);
        ih   = 5'(nih);  iw = 5'(niw);
        is_v = 10'(nih * niw);
        os_v = 10'(o_h * o_w);
        fs_v = 10'((i_d + 1) * k_h * k_w);
    endtask

    task automatic kick();
        @(negedge clk);
        s_init = 1'b1;
    endtask

    task automatic capture(input int n, input int drop_at, input int pulse_at);
        cyc_t o;
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_init = (i == pulse_at);
            if (i == drop_at) run = 1'b0;
            @(negedge clk);
            o = blank();
            o.ki = k_init; o.ex = exec; o.kf = k_fin; o.ot = outr; o.sf = s_fin;
            o.ia = ia; o.wa = wa; o.ra = ra; o.oa = oa;
            obs_q.push_back(o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; s_init = 1'b0;
        set_cfg(0, 1, 2, 2, 2, 2);
        @(negedge clk);
        n_vec++;
        if ({k_init, exec, k_fin, outr, s_fin} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_strobes got %b want 00000", {k_init, exec, k_fin, outr, s_fin});
        end
        n_vec++;
        if ({ia, wa, ra, oa} !== 38'b0) begin
            n_err++;
            $display("FAIL reset_addr got ia%0d wa%0d ra%0d oa%0d want all 0", ia, wa, ra, oa);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    task automatic test_basic();
        int ia0[4] = '{0, 1, 3, 4};
        int n_ex, n_fin;
        set_cfg(0, 1, 2, 2, 2, 2);
        gen_trace();
        kick();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL basic cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs_q[i].ia !== 12'(ia0[i])) begin
                n_err++;
                $display("FAIL basic_ia%0d got %0d want %0d", i, obs_q[i].ia, ia0[i]);
            end
        end
        n_ex = 0;
        n_fin = 0;
        foreach (obs_q[i]) begin
            n_ex += int'(obs_q[i].ex);
            n_fin += int'(obs_q[i].sf);
        end
        n_vec++;
        if (n_ex != 16 || n_fin != 1) begin
            n_err++;
            $display("FAIL basic_counts got exec%0d sfin%0d want exec16 sfin1", n_ex, n_fin);
        end
    endtask

    task automatic test_channels();
        set_cfg(1, 1, 2, 2, 2, 2);
        gen_trace();
        kick();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL chan cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_run_drop();
        set_cfg(0, 1, 2, 2, 2, 2);
        gen_trace();
        for (int i = 11; i < exp_q.size(); i++) exp_q[i] = blank();
        kick();
        capture(exp_q.size(), 10, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL drop cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        run = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({k_init, exec, k_fin, outr, s_fin} !== 5'b0) begin
                n_err++;
                $display("FAIL drop_idle got %b want 00000", {k_init, exec, k_fin, outr, s_fin});
            end
        end
        gen_trace();
        kick();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL restart cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_sinit_ignored();
        int n_fin;
        set_cfg(0, 1, 2, 2, 2, 2);
        gen_trace();
        kick();
        capture(exp_q.size(), -1, 14);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL sinit cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        n_fin = 0;
        foreach (obs_q[i]) n_fin += int'(obs_q[i].sf);
        n_vec++;
        if (n_fin != 1) begin
            n_err++;
            $display("FAIL sinit_sfin got %0d want 1", n_fin);
        end
    endtask

    task automatic test_async_reset();
        set_cfg(0, 1, 2, 2, 2, 2);
        gen_trace();
        kick();
        capture(8, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL arst_pre cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({k_init, exec, k_fin, outr, s_fin} !== 5'b0) begin
            n_err++;
            $display("FAIL arst_strobes got %b want 00000", {k_init, exec, k_fin, outr, s_fin});
        end
        n_vec++;
        if ({ia, wa, ra, oa} !== 38'b0) begin
            n_err++;
            $display("FAIL arst_addr got ia%0d wa%0d ra%0d oa%0d want all 0", ia, wa, ra, oa);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({k_init, exec, k_fin, outr, s_fin} !== 5'b0) begin
                n_err++;
                $display("FAIL arst_idle got %b want 00000", {k_init, exec, k_fin, outr, s_fin});
            end
        end
        gen_trace();
        kick();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (!ok(exp_q[i], obs_q[i])) begin
                n_err++;
                $display("FAIL arst_post cyc%0d got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            set_cfg($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 3),
                    $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
            gen_trace();
            kick();
            capture(exp_q.size(), -1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (!ok(exp_q[i], obs_q[i])) begin
                    n_err++;
                    $display("FAIL rand%0d cyc%0d got %s want %s", t, i, fmt(obs_q[i]), fmt(exp_q[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channels();
        test_run_drop();
        test_sinit_ignored();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter F_NUM, default 16, number of filter cores; od+1 must not exceed it.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 run  in  1  enable level; sampled every cycle.
REQ-005 s_init  in  1  start-of-sample pulse from batch control.
REQ-006 s_fin  out  1  one-cycle pulse when the sample is fully written to the dst buffer.
REQ-007 k_init, k_fin  out  1 each  one-cycle pulses that open and close one output position.
REQ-008 exec  out  1  accumulate strobe to all cores.
REQ-009 ia  out  12  src buffer read address.
REQ-010 wa  out  10  core weight read address.
REQ-011 ra  out  4  core select for the sum readout mux.
REQ-012 outr  out  1  dst buffer write strobe.
REQ-013 oa  out  12  dst buffer write address.
REQ-014 id, od  in  4 each  input/output channel count minus one.
REQ-015 ih, iw, oh, ow, kh, kw  in  5 each  dimension counts (1..31); zero is illegal.
REQ-016 is, os, fs  in  10 each  precomputed ih*iw, oh*ow and (id+1)*kh*kw.

Function
REQ-017 States: IDLE, INIT, EXEC, FIN, OUT, DONE.
REQ-018 IDLE->INIT on s_init&run; s_init in any other state is ignored.
REQ-019 INIT lasts 1 cycle with k_init=1; output position (oy,ox) starts at (0,0) per sample.
REQ-020 EXEC lasts exactly fs cycles with exec=1; wa=n in EXEC cycle n (0..fs-1).
REQ-021 Reads are prefetched one cycle ahead: element n's ia is issued in INIT (n=0) or EXEC cycle n-1, covering 1-cycle src read latency.
REQ-022 Element order: kx fastest, then ky, then channel c; ia=c*is+(oy+ky)*iw+(ox+kx), computed by adders only, no multipliers.
REQ-023 FIN lasts 1 cycle with k_fin=1.
REQ-024 OUT lasts od+1 cycles; ra=r in OUT cycle r.
REQ-025 outr and oa lag ra by exactly one cycle (registered sum mux); oa=r*os+oy*ow+ox.
REQ-026 After the final outr cycle: next (ox,oy), ox fastest, and go to INIT; after (oh-1,ow-1), go to DONE.
REQ-027 DONE lasts 1 cycle with s_fin=1, then IDLE.
REQ-028 run=0 in any non-IDLE state: next cycle all strobes 0, state IDLE, no s_fin; a pending delayed outr is dropped.
REQ-029 Strobe outputs (k_init, k_fin, exec, outr, s_fin) are 0 outside their states; address outputs hold last value when idle.
REQ-030 Address arithmetic is modulo 2^width; configurations exceeding the widths are illegal and unchecked.

Reset
REQ-031 rst_n low: state IDLE, all strobes 0, ia/wa/oa/ra 0, all counters 0, asynchronously.
REQ-032 Reset mid-sample aborts like REQ-028; the first post-reset start requires a fresh s_init.

Configuration
REQ-033 Macro CONV_SCHED_STALL_EN adds input stall (1 bit).
REQ-034 With it defined, stall=1 freezes state, counters and addresses and forces exec/outr/k_init/k_fin/s_fin to 0 that cycle; the delayed outr is also held and released with the following cycle.
REQ-035 Without it, no stall port exists and the sequence never pauses.

Structure
REQ-036 Shared package conv_pkg holds the state enum and width constants (IA_W=12, WA_W=10, RA_W=4).
REQ-037 One sub-module, conv_addr_gen, holds the kx/ky/c counters and the incremental ia/wa generator.
REQ-038 Readout and outr delay stay in conv_sched.

Verification
REQ-039 id=0, ih=iw=3, kh=kw=2, oh=ow=2, od=1, fs=4 -> exec 4 cycles per position; ia sequence for position (0,0) 0,1,3,4; oa 0,4 then 1,5; s_fin once after 4 positions.
REQ-040 id=1, is=9, same kernel -> for position (0,1) ia 1,2,4,5,10,11,13,14; wa 0..7.
REQ-041 run dropped during EXEC of the second position -> strobes 0 next cycle, IDLE, no s_fin; a following s_init restarts at (0,0).
REQ-042 s_init pulsed during OUT -> ignored; exactly one s_fin.
REQ-043 rst_n asserted mid-OUT -> outr and state clear immediately without a clock edge.
REQ-044 CONV_SCHED_STALL_EN: stall held 3 cycles mid-EXEC -> exec count still fs, ia/wa sequence unchanged, total latency +3.
